pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_target_mux.sv | 40 ++++
 rtl/pc_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter sequencer.
//   - pc_src selector codes (4-bit)
//   - FSM state type and constants (RUN, FAULT)
package pc_pkg;

  localparam int unsigned PCSRC_W = 4;

  typedef logic [PCSRC_W-1:0] pcsrc_t;

  localparam pcsrc_t PCSRC_ALU    = 4'd0;
  localparam pcsrc_t PCSRC_EXC    = 4'd1;
  localparam pcsrc_t PCSRC_ALUOUT = 4'd2;
  localparam pcsrc_t PCSRC_JUMP   = 4'd3;
  localparam pcsrc_t PCSRC_EPC    = 4'd4;

  typedef logic [0:0] state_t;

  localparam state_t RUN   = 1'b0;
  localparam state_t FAULT = 1'b1;

endpackage : pc_pkg

// File: rtl/pc_target_mux.sv
// Combinational next-PC target selection.
//   pc_src      : selector (0..4 valid, 5..15 invalid)
//   alu_result  : combinational ALU output
//   alu_out     : registered ALU output
//   jump_target : pre-formed jump address
//   epc         : saved exception PC
//   target_c    : selected target (zero when selector invalid)
//   valid_c     : selector is one of the defined encodings
module pc_target_mux
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned EXC_VEC = 4
) (
  input  logic [PCSRC_W-1:0] pc_src,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [WIDTH-1:0]   jump_target,
  input  logic [WIDTH-1:0]   epc,
  output logic [WIDTH-1:0]   target_c,
  output logic               valid_c
);

  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);

  // Target decode
  always_comb begin
    target_c = '0;
    valid_c  = 1'b1;
    case (pc_src)
      PCSRC_ALU:    target_c = alu_result;
      PCSRC_EXC:    target_c = EXC_PC;
      PCSRC_ALUOUT: target_c = alu_out;
      PCSRC_JUMP:   target_c = jump_target;
      PCSRC_EPC:    target_c = epc;
      default:      valid_c  = 1'b0;
    endcase
  end

endmodule : pc_target_mux

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with exception entry and misaligned-target fault.
//   clk, reset        : clock, asynchronous active-low reset
//   pc_src            : target selector
//   alu_result        : combinational ALU output
//   alu_out           : registered ALU output (branch target)
//   jump_target       : pre-formed jump address
//   pc_write          : unconditional PC write request
//   pc_write_cond     : conditional PC write request
//   branch_taken      : qualifies pc_write_cond
//   exc_req           : exception request (level)
//   pc, epc           : program counter, saved exception PC
//   misalign          : high during the single FAULT cycle
//   busy              : high whenever not in RUN
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned EXC_VEC     = 4,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PCSRC_W-1:0] pc_src,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [WIDTH-1:0]   jump_target,
  input  logic               pc_write,
  input  logic               pc_write_cond,
  input  logic               branch_taken,
  input  logic               exc_req,
  output logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   epc,
  output logic               misalign,
  output logic               busy
);

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] EXC_PC    = WIDTH'(EXC_VEC);

  if ((WIDTH < 8) || ((WIDTH % 8) != 0)) begin : g_bad_width
    $error("pc_sequencer: WIDTH must be a multiple of 8 and at least 8");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] epc_nxt;
  logic [WIDTH-1:0] target;
  logic             target_valid;
  logic             write_en;
  logic             target_misaligned;

  pc_target_mux #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC)
  ) u_target_mux (
    .pc_src      (pc_src),
    .alu_result  (alu_result),
    .alu_out     (alu_out),
    .jump_target (jump_target),
    .epc         (epc),
    .target_c    (target),
    .valid_c     (target_valid)
  );

  assign write_en          = pc_write | (pc_write_cond & branch_taken);
  assign target_misaligned = ALIGN_CHECK && (target[1:0] != 2'b00);

  // State, PC and EPC registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      pc    <= RESET_VAL;
      epc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      epc   <= epc_nxt;
    end
  end

  // Next-state and next-PC; exceptions win over writes, FAULT ignores all requests
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    epc_nxt   = epc;
    case (state)
      RUN: begin
        if (exc_req) begin
          epc_nxt = pc;
          pc_nxt  = EXC_PC;
        end else if (write_en && target_valid) begin
          if (target_misaligned) begin
            epc_nxt   = pc;
            state_nxt = FAULT;
          end else begin
            pc_nxt = target;
          end
        end
      end
      FAULT: begin
        pc_nxt    = EXC_PC;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Status outputs decoded from the state register only
  assign misalign = (state == FAULT);
  assign busy     = (state != RUN);

endmodule : pc_sequencer
